// File: rtl/max7219_scheduler.sv
// Word-level scheduler for a MAX7219 cascade: power-on init sequence, periodic
// digit sweeps from a raw segment frame, and host writes interleaved at word boundaries.
module max7219_scheduler #(
  parameter int NUM_CASCADES = 1,
  parameter int INTENSITY    = 7,
  parameter int REFRESH_DIV  = 50000
) (
  input  logic                        clk,
  input  logic                        reset_sw,
  input  logic [64*NUM_CASCADES-1:0]  frame,
  input  logic                        frame_dirty,
  input  logic                        host_req,
  input  logic [7:0]                  host_addr,
  input  logic [7:0]                  host_data,
  output logic                        host_ack,
  output logic                        spi_valid,
  input  logic                        spi_ready,
  output logic [7:0]                  spi_addr,
  output logic [8*NUM_CASCADES-1:0]   spi_data,
  input  logic                        spi_done,
  output logic                        init_done,
  output logic                        busy
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = 8 * NUM_CASCADES;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_DIV - 1);

  localparam logic [2:0] S_INIT_ISSUE = 3'd0;
  localparam logic [2:0] S_INIT_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;

  function automatic logic [7:0] init_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    init_addr = 8'h0F;
      3'd1:    init_addr = 8'h0C;
      3'd2:    init_addr = 8'h0B;
      3'd3:    init_addr = 8'h0A;
      3'd4:    init_addr = 8'h09;
      default: init_addr = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] init_data(input logic [2:0] idx);
    case (idx)
      3'd0:    init_data = 8'h00;
      3'd1:    init_data = 8'h01;
      3'd2:    init_data = 8'h07;
      3'd3:    init_data = 8'(INTENSITY);
      3'd4:    init_data = 8'h00;
      default: init_data = 8'h00;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic [2:0]    digit_q, digit_d;
  logic          sweep_q, sweep_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          init_done_q, init_done_d;
  logic          host_ack_q, host_ack_d;
  logic          is_host_q, is_host_d;
  logic          valid_q, valid_d;
  logic [7:0]    addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          wrap_s;
  logic          pending_clr_s;
  logic [DW-1:0] sweep_word_s;

  // Gather digit digit_q of every cascade into one word.
  always_comb begin
    sweep_word_s = '0;
    for (int c = 0; c < NUM_CASCADES; c++) begin
      sweep_word_s[c*8 +: 8] = frame[(c*8 + int'(digit_q))*8 +: 8];
    end
  end

  // Next-state logic: timer, arbitration and the word handshake.
  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    digit_d       = digit_q;
    sweep_d       = sweep_q;
    timer_d       = timer_q;
    init_done_d   = init_done_q;
    host_ack_d    = 1'b0;
    is_host_d     = is_host_q;
    valid_d       = valid_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wrap_s        = 1'b0;
    pending_clr_s = 1'b0;

    if (init_done_q) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        wrap_s  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      S_INIT_ISSUE: begin
        if (!valid_q) begin
          valid_d   = 1'b1;
          is_host_d = 1'b0;
          addr_d    = init_addr(init_idx_q);
          data_d    = {NUM_CASCADES{init_data(init_idx_q)}};
        end else if (spi_ready) begin
          valid_d = 1'b0;
          state_d = S_INIT_WAIT;
        end else begin
          valid_d = 1'b1;
        end
      end
      S_INIT_WAIT: begin
        if (spi_done) begin
          if (init_idx_q == 3'd4) begin
            init_idx_d  = 3'd0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            state_d    = S_INIT_ISSUE;
          end
        end else begin
          state_d = S_INIT_WAIT;
        end
      end
      S_IDLE: begin
        // Fixed priority: host, then a sweep already under way, then a new sweep.
        if (host_req && init_done_q) begin
          valid_d   = 1'b1;
          is_host_d = 1'b1;
          addr_d    = host_addr;
          data_d    = {NUM_CASCADES{host_data}};
          state_d   = S_ISSUE;
        end else if (sweep_q || pending_q) begin
          valid_d       = 1'b1;
          is_host_d     = 1'b0;
          addr_d        = {5'd0, digit_q} + 8'd1;
          data_d        = sweep_word_s;
          digit_d       = digit_q + 3'd1;
          sweep_d       = (digit_q != 3'd7);
          pending_clr_s = !sweep_q;
          state_d       = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (spi_ready) begin
          valid_d    = 1'b0;
          host_ack_d = is_host_q;
          state_d    = S_WAIT_DONE;
        end else begin
          valid_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_INIT_ISSUE;
      end
    endcase

    // A set in the same cycle as a sweep start wins, so newer frame data is not lost.
    pending_d = frame_dirty | wrap_s | (pending_q & ~pending_clr_s);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      state_q     <= S_INIT_ISSUE;
      init_idx_q  <= 3'd0;
      digit_q     <= 3'd0;
      sweep_q     <= 1'b0;
      pending_q   <= 1'b0;
      timer_q     <= '0;
      init_done_q <= 1'b0;
      host_ack_q  <= 1'b0;
      is_host_q   <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      digit_q     <= digit_d;
      sweep_q     <= sweep_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      init_done_q <= init_done_d;
      host_ack_q  <= host_ack_d;
      is_host_q   <= is_host_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign host_ack  = host_ack_q;
  assign spi_valid = valid_q;
  assign spi_addr  = addr_q;
  assign spi_data  = data_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_max7219_scheduler.sv
// Bench for max7219_scheduler: a word-level reference model checked every cycle,
// directed sequences and a host-write vector table, then randomized traffic.
module tb_max7219_scheduler;

  localparam int NC  = 2;
  localparam int INT = 7;
  localparam int DIV = 5000;
  localparam int FW  = 64 * NC;
  localparam int DW  = 8 * NC;

  logic          clk = 1'b0;
  logic          reset_sw;
  logic [FW-1:0] frame;
  logic          frame_dirty;
  logic          host_req;
  logic [7:0]    host_addr;
  logic [7:0]    host_data;
  logic          host_ack;
  logic          spi_valid;
  logic          spi_ready;
  logic [7:0]    spi_addr;
  logic [DW-1:0] spi_data;
  logic          spi_done;
  logic          init_done;
  logic          busy;

  max7219_scheduler #(.NUM_CASCADES(NC), .INTENSITY(INT), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset_sw(reset_sw), .frame(frame), .frame_dirty(frame_dirty),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_addr(spi_addr), .spi_data(spi_data),
    .spi_done(spi_done), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word slots (0 free, 1 offered, 2 in flight), init progress, sweep bookkeeping.
  logic [7:0] init_a [5] = '{8'h0F, 8'h0C, 8'h0B, 8'h0A, 8'h09};
  logic [7:0] init_v [5] = '{8'h00, 8'h01, 8'h07, 8'(INT), 8'h00};
  int            m_phase, m_init_idx, m_next_digit, m_cnt;
  bit            m_init_done, m_pending, m_sweep, m_is_host, m_ack;
  logic [7:0]    m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_phase = 0; m_init_idx = 0; m_next_digit = 0; m_cnt = 0;
    m_init_done = 0; m_pending = 0; m_sweep = 0; m_is_host = 0; m_ack = 0;
    m_addr = 8'h00; m_data = '0;
  endtask

  task automatic model_edge(input logic hreq, input logic [7:0] ha, input logic [7:0] hd,
                            input logic [FW-1:0] fr, input logic dirty, input logic rdy,
                            input logic dn);
    bit wrap = 0;
    if (m_init_done) begin
      m_cnt++;
      if (m_cnt == DIV) begin m_cnt = 0; wrap = 1; end
    end
    m_ack = 0;
    case (m_phase)
      0: begin
        if (m_init_idx < 5) begin
          m_addr = init_a[m_init_idx]; m_data = {NC{init_v[m_init_idx]}};
          m_is_host = 0; m_phase = 1;
        end else if (hreq) begin
          m_addr = ha; m_data = {NC{hd}}; m_is_host = 1; m_phase = 1;
        end else if (m_sweep || m_pending) begin
          if (!m_sweep) begin m_sweep = 1; m_next_digit = 0; m_pending = 0; end
          m_addr = 8'(m_next_digit + 1);
          for (int c = 0; c < NC; c++) m_data[c*8 +: 8] = fr[(c*8 + m_next_digit)*8 +: 8];
          m_next_digit++;
          if (m_next_digit == 8) begin m_sweep = 0; m_next_digit = 0; end
          m_is_host = 0; m_phase = 1;
        end
      end
      1: if (rdy) begin m_phase = 2; m_ack = m_is_host; end
      default: if (dn) begin
        m_phase = 0;
        if (m_init_idx < 5) begin
          m_init_idx++;
          if (m_init_idx == 5) m_init_done = 1;
        end
      end
    endcase
    if (dirty || wrap) m_pending = 1;
  endtask

  task automatic check_outputs();
    chk("spi_valid", spi_valid, (m_phase == 1));
    if (m_phase == 1) begin
      chk("spi_addr", spi_addr, m_addr);
      chk("spi_data", spi_data, m_data);
    end
    chk("host_ack", host_ack, m_ack);
    chk("init_done", init_done, m_init_done);
    chk("busy", busy, !(m_phase == 0 && m_init_done));
  endtask

  // Serializer model and transfer log.
  int            ser_mode = 0;   // 0: ready=1 fixed delay, 1: random, 2: ready held low
  int            ser_delay = 20;
  int            ser_cnt = 0;
  bit            prev_valid = 0;
  logic [7:0]    prev_addr = 8'h00;
  logic [DW-1:0] prev_data = '0;
  logic [7:0]    log_addr [$];
  logic [DW-1:0] log_data [$];
  int            ack_total = 0;
  int            ack_early = 0;

  task automatic cycle();
    logic hreq, dirty, rdy, dn, rst;
    logic [7:0] ha, hd;
    logic [FW-1:0] fr;
    bit xfer;
    hreq = host_req; ha = host_addr; hd = host_data; fr = frame;
    dirty = frame_dirty; rdy = spi_ready; dn = spi_done; rst = reset_sw;
    @(posedge clk); #1;
    xfer = prev_valid && rdy && !rst && !reset_sw;
    if (xfer) begin log_addr.push_back(prev_addr); log_data.push_back(prev_data); end
    if (rst || reset_sw) model_reset();
    else model_edge(hreq, ha, hd, fr, dirty, rdy, dn);
    check_outputs();
    if (host_ack) begin ack_total++; if (!init_done) ack_early++; end
    spi_done = 1'b0;
    if (reset_sw) ser_cnt = 0;
    else begin
      if (xfer) ser_cnt = (ser_mode == 1) ? int'($urandom_range(1, 8)) : ser_delay;
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) spi_done = 1'b1;
      end else if (ser_mode == 1 && !xfer && $urandom_range(0, 19) == 0) begin
        spi_done = 1'b1;
      end
    end
    spi_ready = (ser_mode == 2) ? 1'b0 : (ser_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (host_req && host_ack) host_req = 1'b0;
    frame_dirty = 1'b0;
    prev_valid = spi_valid; prev_addr = spi_addr; prev_data = spi_data;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (log_addr.size() < n && k < budget) begin cycle(); k++; end
    chk("word_wait_timeout", (log_addr.size() >= n), 1);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete();
  endtask

  typedef struct {
    logic [7:0]  h_addr;
    logic [7:0]  h_data;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
  } hvec_t;

  hvec_t hv [4];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before, k;
    logic [7:0]    hold_a;
    logic [DW-1:0] hold_d;
    hv[0] = '{8'h0A, 8'h03, 8'h0A, 16'h0303};
    hv[1] = '{8'h01, 8'h7F, 8'h01, 16'h7F7F};
    hv[2] = '{8'h0F, 8'h01, 8'h0F, 16'h0101};
    hv[3] = '{8'h0F, 8'h00, 8'h0F, 16'h0000};

    reset_sw = 1'b1; frame = '0; frame_dirty = 1'b0; host_req = 1'b0;
    host_addr = 8'h00; host_data = 8'h00; spi_ready = 1'b1; spi_done = 1'b0;
    model_reset();
    repeat (3) cycle();
    chk("reset_spi_valid", spi_valid, 0);
    chk("reset_spi_addr", spi_addr, 8'h00);
    chk("reset_spi_data", spi_data, 0);
    chk("reset_host_ack", host_ack, 0);
    chk("reset_init_done", init_done, 0);
    chk("reset_busy", busy, 1);

    // Init sequence, with a host request already waiting.
    reset_sw = 1'b0;
    host_req = 1'b1; host_addr = 8'h0C; host_data = 8'h01;
    clear_log();
    cycle();
    chk("first_cycle_valid", spi_valid, 1);
    wait_words(6, 600);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      chk("init_addr", log_addr[i], init_a[i]);
      chk("init_data", log_data[i], {NC{init_v[i]}});
    end
    if (log_addr.size() > 5) chk("post_init_host_addr", log_addr[5], 8'h0C);
    repeat (25) cycle();
    chk("no_early_ack", ack_early, 0);

    // Host write vectors.
    for (int i = 0; i < 4; i++) begin
      clear_log();
      host_req = 1'b1; host_addr = hv[i].h_addr; host_data = hv[i].h_data;
      acks_before = ack_total;
      wait_words(1, 100);
      repeat (25) cycle();
      if (log_addr.size() > 0) begin
        chk("hvec_addr", log_addr[0], hv[i].e_addr);
        chk("hvec_data", log_data[0], hv[i].e_data);
      end
      chk("hvec_ack_count", ack_total - acks_before, 1);
    end

    // Sweep from a dirty frame.
    for (int d = 0; d < 8; d++) begin
      frame[d*8 +: 8]       = 8'(8'h10 + d);
      frame[(8 + d)*8 +: 8] = 8'(8'h20 + d);
    end
    frame[(8 + 3)*8 +: 8] = 8'hA5;
    clear_log();
    frame_dirty = 1'b1;
    wait_words(8, 400);
    repeat (40) cycle();
    chk("sweep_word_count", log_addr.size(), 8);
    for (int d = 0; d < 8 && d < log_addr.size(); d++) begin
      chk("sweep_addr", log_addr[d], 8'(d + 1));
      chk("sweep_data", log_data[d], {(d == 3) ? 8'hA5 : 8'(8'h20 + d), 8'(8'h10 + d)});
    end

    // Host write during digit 2.
    clear_log();
    acks_before = ack_total;
    frame_dirty = 1'b1;
    k = 0;
    while (!(spi_valid && spi_addr == 8'h03) && k < 300) begin cycle(); k++; end
    chk("digit2_seen", (spi_valid && spi_addr == 8'h03), 1);
    host_req = 1'b1; host_addr = 8'h0A; host_data = 8'h03;
    wait_words(9, 600);
    repeat (40) cycle();
    chk("interleave_count", log_addr.size(), 9);
    if (log_addr.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("interleave_addr", log_addr[i], (i < 3) ? 8'(i + 1) : (i == 3) ? 8'h0A : 8'(i));
      end
      chk("interleave_host_data", log_data[3], 16'h0303);
    end
    chk("interleave_ack_count", ack_total - acks_before, 1);

    // Three dirty pulses during a sweep coalesce into one extra sweep.
    clear_log();
    frame_dirty = 1'b1;
    wait_words(2, 200);
    for (int p = 0; p < 3; p++) begin
      frame_dirty = 1'b1;
      repeat (10) cycle();
    end
    wait_words(16, 1000);
    repeat (80) cycle();
    chk("coalesce_count", log_addr.size(), 16);
    for (int i = 8; i < 16 && i < log_addr.size(); i++) chk("coalesce_addr", log_addr[i], 8'(i - 7));

    // Ready held low: outputs frozen; then reset mid-sweep.
    ser_mode = 2;
    frame_dirty = 1'b1;
    k = 0;
    while (!spi_valid && k < 50) begin cycle(); k++; end
    hold_a = spi_addr; hold_d = spi_data;
    frame = ~frame;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (i % 25 == 0) begin
        chk("stall_valid", spi_valid, 1);
        chk("stall_addr", spi_addr, hold_a);
        chk("stall_data", spi_data, hold_d);
      end
    end
    ser_mode = 0;
    clear_log();
    wait_words(3, 200);
    ser_mode = 2;
    k = 0;
    while (!spi_valid && k < 100) begin cycle(); k++; end
    chk("pre_reset_valid", spi_valid, 1);
    reset_sw = 1'b1;
    #1;
    chk("async_reset_valid", spi_valid, 0);
    ser_mode = 0;
    cycle(); cycle();
    reset_sw = 1'b0;
    clear_log();
    wait_words(1, 50);
    if (log_addr.size() > 0) begin
      chk("restart_addr", log_addr[0], 8'h0F);
      chk("restart_data", log_data[0], 16'h0000);
    end

    // Randomized traffic against the model, long enough for timer wraps.
    ser_mode = 1;
    for (int i = 0; i < 16000; i++) begin
      if (!host_req && $urandom_range(0, 39) == 0) begin
        host_req = 1'b1; host_addr = 8'($urandom); host_data = 8'($urandom);
      end
      if ($urandom_range(0, 79) == 0) frame_dirty = 1'b1;
      if ($urandom_range(0, 29) == 0)
        for (int w = 0; w < FW / 32; w++) frame[w*32 +: 32] = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
